regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
// - Shares the register file's single write port among NUM_REQ writeback sources (ALU, load, move/immediate).
// - Fair round-robin arbitration, valid/ready handshake per source, one registered write stage.
// - Exports pending-write info so the datapath can forward or stall on registers not yet written.
// PARAMETERS
// NUM_REQ  3  number of writeback requesters (2..8)
// DATA_W   8  register data width
// REG_AW   2  register index width (2**REG_AW registers)
// PORTS
// clk            in   1                clock
// reset          in   1                reset, asynchronous, active-high
// req_valid      in   NUM_REQ          requester i has a write pending
// req_reg        in   NUM_REQ*REG_AW   target reg of requester i, slice [i*REG_AW +: REG_AW]
// req_data       in   NUM_REQ*DATA_W   write data of requester i, slice [i*DATA_W +: DATA_W]
// req_ready      out  NUM_REQ          one-hot grant; handshake when valid&ready at posedge
// wb_stall       in   1                1 = issue no new grants this cycle
// rf_write_en    out  1                to regfile write_en (registered)
// rf_write_reg   out  REG_AW           to regfile write_reg (registered)
// rf_write_value out  DATA_W           to regfile write_value (registered)
// pending_mask   out  2**REG_AW        bit r = 1 while the write stage holds a write to reg r
// BEHAVIOUR
// - Reset: rr_ptr=0; rf_write_en=0, rf_write_reg=0, rf_write_value=0; pending_mask=0; req_ready=0 while reset high.
// - Arbitration (combinational): search req_valid from rr_ptr upward, wrapping at NUM_REQ-1 -> 0;
//   first valid index g gets req_ready[g]=1, all others 0. No valid or wb_stall=1 -> req_ready=0.
// - req_ready may depend on req_valid; requesters must hold valid, reg and data stable until granted.
// - rr_ptr update at posedge on handshake: rr_ptr <= (g==NUM_REQ-1) ? 0 : g+1; else unchanged.
// - Write stage: on handshake at posedge N, load rf_write_en=1, rf_write_reg=req_reg[g], rf_write_value=req_data[g];
//   no handshake -> rf_write_en<=0, reg/value hold. Regfile captures at posedge N+1; value readable from cycle N+2.
// - Throughput: one write per cycle; write stage never back-pressures (regfile always accepts).
// - pending_mask = rf_write_en ? (1 << rf_write_reg) : 0; purely decoded from the write-stage registers.
// - Same target reg from two requesters in one cycle: granted one written first, other next grant; last writer wins.
// - wb_stall=1: no grant, rr_ptr held; a write already in the write stage still issues.
// - Single requester continuously valid: granted every cycle (rr_ptr wraps back to it).
// - Reset mid-operation: write-stage contents dropped, rf_write_en forced 0, no write reaches regfile.
// - Register 0 is an ordinary register; writes to it are not filtered.
// CONFIGURATION
// - Macro WB_ARB_STATS_EN.
//   Defined: adds outputs grant_cnt (NUM_REQ*16, 16-bit saturating handshake count per requester)
//   and stall_cnt (16, saturating; +1 each cycle any req_valid=1 with no grant). Both 0 at reset; stick at 16'hFFFF.
//   Undefined: ports and counters absent; arbitration and write timing identical.
// TESTING
// 1. Reset mid-write: handshake on req 0, assert reset next cycle -> rf_write_en=0, pending_mask=0, regfile unchanged.
// 2. req 0 only: reg=2, data=8'hA5 -> req_ready[0]=1 cycle N; rf_write_en=1, reg=2, value=A5, pending_mask=4'b0100 cycle N+1.
// 3. All 3 valid continuously from reset -> grant order 0,1,2,0,1,2; one write per cycle, no gaps.
// 4. req 0 and req 2 both write reg 1 (8'h11, 8'h22) same cycle -> 11 written then 22; final reg1=8'h22.
// 5. wb_stall=1 for 3 cycles with req 1 valid -> req_ready=0, rr_ptr held; grant on first cycle stall=0.
// 6. WB_ARB_STATS_EN: req 1 stalled 4 cycles then granted twice -> stall_cnt=4, grant_cnt[1]=2; saturation at FFFF.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin arbiter sharing the register file write port
//
// Shares the single register-file write port among NUM_REQ writeback sources.
// Fair round-robin grant, valid/ready handshake per source, one registered
// write stage, and a decoded pending-write mask for forwarding/stall logic.
//
// Optional feature: define WB_ARB_STATS_EN to add the grant_cnt/stall_cnt
// statistics outputs (arbitration and write timing are unchanged).
//
// Ports:
//   clk            in   clock
//   reset          in   asynchronous, active-high reset
//   req_valid      in   [NUM_REQ]         requester i has a write pending
//   req_reg        in   [NUM_REQ*REG_AW]  target reg of requester i
//   req_data       in   [NUM_REQ*DATA_W]  write data of requester i
//   req_ready      out  [NUM_REQ]         one-hot grant
//   wb_stall       in   suppress new grants this cycle
//   rf_write_en    out  registered regfile write enable
//   rf_write_reg   out  registered regfile write index
//   rf_write_value out  registered regfile write data
//   pending_mask   out  [2**REG_AW]       reg r held in the write stage
//   grant_cnt      out  [NUM_REQ*16]      (WB_ARB_STATS_EN) saturating grants per requester
//   stall_cnt      out  [16]              (WB_ARB_STATS_EN) saturating starved cycles

module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 8,
  parameter int REG_AW  = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*REG_AW-1:0]   req_reg,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        wb_stall,
  output logic                        rf_write_en,
  output logic [REG_AW-1:0]           rf_write_reg,
  output logic [DATA_W-1:0]           rf_write_value,
  output logic [2**REG_AW-1:0]        pending_mask
`ifdef WB_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]       grant_cnt,
  output logic [15:0]                 stall_cnt
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_found;
  logic              handshake;
  logic [PTR_W:0]    cand;
  logic [REG_AW-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  // Search from rr_ptr upward with wrap; one extra bit in cand holds the
  // unwrapped sum so the wrap is a single conditional subtract.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!grant_found && req_valid[cand[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Grants are withheld while reset is high so no requester sees a handshake.
  assign handshake = grant_found & ~wb_stall & ~reset;
  assign req_ready = handshake ? (NUM_REQ'(1) << grant_idx) : '0;

  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == PTR_W'(i)) begin
        sel_reg  = req_reg[i*REG_AW +: REG_AW];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (handshake) begin
      rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  // Write stage: reg/value hold when idle so the regfile sees stable inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_write_en    <= 1'b0;
      rf_write_reg   <= '0;
      rf_write_value <= '0;
    end else begin
      rf_write_en <= handshake;
      if (handshake) begin
        rf_write_reg   <= sel_reg;
        rf_write_value <= sel_data;
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    if (rf_write_en) pending_mask[rf_write_reg] = 1'b1;
  end

`ifdef WB_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (handshake && grant_idx == PTR_W'(i) && grant_cnt[i*16 +: 16] != 16'hFFFF)
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
      if (|req_valid && !handshake && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
//
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model (round-robin pointer, expected write stage, model regfile).

module tb_regfile_wb_arbiter;

  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 8;
  localparam int REG_AW  = 2;
  localparam int NREG    = 2**REG_AW;

  logic                      clk;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*REG_AW-1:0] req_reg;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      wb_stall;
  logic                      rf_write_en;
  logic [REG_AW-1:0]         rf_write_reg;
  logic [DATA_W-1:0]         rf_write_value;
  logic [NREG-1:0]           pending_mask;
`ifdef WB_ARB_STATS_EN
  logic [NUM_REQ*16-1:0]     grant_cnt;
  logic [15:0]               stall_cnt;
`endif

  regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_reg(req_reg),
    .req_data(req_data),
    .req_ready(req_ready),
    .wb_stall(wb_stall),
    .rf_write_en(rf_write_en),
    .rf_write_reg(rf_write_reg),
    .rf_write_value(rf_write_value),
    .pending_mask(pending_mask)
`ifdef WB_ARB_STATS_EN
    ,
    .grant_cnt(grant_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state
  int              m_ptr;
  bit              m_en;
  logic [REG_AW-1:0] m_reg;
  logic [DATA_W-1:0] m_val;
  logic [DATA_W-1:0] m_rf [NREG];
  logic [DATA_W-1:0] o_rf [NREG];
  int              last_grant;
  logic [NUM_REQ-1:0] seen_ready;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick();
    if (reset || wb_stall) return -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NUM_REQ;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_clear();
    m_ptr = 0;
    m_en  = 1'b0;
    m_reg = '0;
    m_val = '0;
  endtask

  // One clock: check at negedge, update model at posedge, return at posedge+1.
  task automatic step();
    int g;
    logic [NUM_REQ-1:0] exp_ready;
    logic [NREG-1:0]    exp_pend;
    @(negedge clk);
    g = pick();
    exp_ready = (g < 0) ? '0 : (NUM_REQ'(1) << g);
    exp_pend  = m_en ? (NREG'(1) << m_reg) : '0;
    check("req_ready", req_ready, exp_ready);
    check("rf_write_en", rf_write_en, m_en);
    check("rf_write_reg", rf_write_reg, m_reg);
    check("rf_write_value", rf_write_value, m_val);
    check("pending_mask", pending_mask, exp_pend);
    seen_ready = req_ready;
    if (rf_write_en) o_rf[rf_write_reg] = rf_write_value;
    if (m_en) m_rf[m_reg] = m_val;
    last_grant = g;
    @(posedge clk);
    if (reset) begin
      model_clear();
    end else if (g >= 0) begin
      m_ptr = (g == NUM_REQ - 1) ? 0 : g + 1;
      m_en  = 1'b1;
      m_reg = req_reg[g*REG_AW +: REG_AW];
      m_val = req_data[g*DATA_W +: DATA_W];
    end else begin
      m_en = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    step();
    reset = 1'b0;
  endtask

  task automatic set_req(input int i, input bit v, input logic [REG_AW-1:0] r, input logic [DATA_W-1:0] d);
    req_valid[i] = v;
    req_reg[i*REG_AW +: REG_AW] = r;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_reg = '0;
    req_data = '0;
    wb_stall = 1'b0;
    model_clear();
    for (int r = 0; r < NREG; r++) begin
      m_rf[r] = '0;
      o_rf[r] = '0;
    end
    #1;
    step();
    check("reset_wr_en", rf_write_en, 1'b0);
    check("reset_pending", pending_mask, '0);
    reset = 1'b0;

    // 1: handshake then reset next cycle drops the write
    set_req(0, 1'b1, 2'd1, 8'h3C);
    step();
    set_req(0, 1'b0, 2'd0, 8'h00);
    reset = 1'b1;
    model_clear();
    #1;
    check("t1_wr_en_dropped", rf_write_en, 1'b0);
    check("t1_pending_dropped", pending_mask, '0);
    step();
    reset = 1'b0;
    step();
    check("t1_rf_unchanged", o_rf[1], 8'h00);

    // 2: single write reg 2 = A5
    set_req(0, 1'b1, 2'd2, 8'hA5);
    step();
    check("t2_ready", seen_ready, 3'b001);
    set_req(0, 1'b0, 2'd0, 8'h00);
    check("t2_wr_en", rf_write_en, 1'b1);
    check("t2_wr_reg", rf_write_reg, 2'd2);
    check("t2_wr_value", rf_write_value, 8'hA5);
    check("t2_pending", pending_mask, 4'b0100);
    step();

    // 3: all valid from reset -> 0,1,2,0,1,2 back to back
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, REG_AW'(i), DATA_W'(8'h40 + i));
    for (int n = 0; n < 6; n++) begin
      step();
      check("t3_order", seen_ready, NUM_REQ'(1) << (n % NUM_REQ));
      check("t3_no_gap", rf_write_en, 1'b1);
    end
    req_valid = '0;
    step();

    // 4: reqs 0 and 2 both target reg 1; last writer wins
    do_reset();
    set_req(0, 1'b1, 2'd1, 8'h11);
    set_req(2, 1'b1, 2'd1, 8'h22);
    step();
    check("t4_first", seen_ready, 3'b001);
    set_req(0, 1'b0, 2'd0, 8'h00);
    step();
    check("t4_second", seen_ready, 3'b100);
    set_req(2, 1'b0, 2'd0, 8'h00);
    step();
    step();
    check("t4_reg1", o_rf[1], 8'h22);

    // 5: stall holds off req 1 for 3 cycles
    set_req(1, 1'b1, 2'd3, 8'h5A);
    wb_stall = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      check("t5_stalled", seen_ready, 3'b000);
    end
    wb_stall = 1'b0;
    step();
    check("t5_grant", seen_ready, 3'b010);
    set_req(1, 1'b0, 2'd0, 8'h00);
    step();

`ifdef WB_ARB_STATS_EN
    // 6: statistics counters
    do_reset();
    set_req(1, 1'b1, 2'd0, 8'h77);
    wb_stall = 1'b1;
    for (int n = 0; n < 4; n++) step();
    wb_stall = 1'b0;
    step();
    step();
    set_req(1, 1'b0, 2'd0, 8'h00);
    step();
    check("t6_stall_cnt", stall_cnt, 16'd4);
    check("t6_grant_cnt1", grant_cnt[16 +: 16], 16'd2);
    check("t6_grant_cnt0", grant_cnt[0 +: 16], 16'd0);
`endif

    // randomized traffic; granted requesters may re-request, others hold
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        do_reset();
      end else begin
        step();
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (last_grant == i || !req_valid[i]) begin
          if ($urandom_range(0, 99) < 55)
            set_req(i, 1'b1, REG_AW'($urandom), DATA_W'($urandom));
          else
            set_req(i, 1'b0, REG_AW'($urandom), DATA_W'($urandom));
        end
      end
      wb_stall = ($urandom_range(0, 4) == 0);
    end
    req_valid = '0;
    wb_stall = 1'b0;
    step();
    step();
    for (int r = 0; r < NREG; r++) check("final_regfile", o_rf[r], m_rf[r]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
